// File: rtl/imm_ext_pkg.sv
// imm_ext_pkg: shared types for the registered immediate-generation stage.
// Holds format-select encodings, handshake state encodings and XLEN limits.
package imm_ext_pkg;

    typedef enum logic [2:0] {
        IMM_I   = 3'b000,
        IMM_S   = 3'b001,
        IMM_B   = 3'b010,
        IMM_U   = 3'b011,
        IMM_J   = 3'b100,
        IMM_Z   = 3'b101,
        IMM_SH  = 3'b110,
        IMM_ILL = 3'b111
    } imm_src_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } imm_state_e;

    localparam int XLEN_32 = 32;
    localparam int XLEN_64 = 64;

    function automatic bit xlen_ok(int x);
        return (x == XLEN_32) || (x == XLEN_64);
    endfunction

endpackage

// File: rtl/imm_decode.sv
// imm_decode: combinational immediate extraction and extension to XLEN.
// Ports: instr_i (32b word), imm_src_i (format) -> imm_ext_o, imm_err_o.
module imm_decode
    import imm_ext_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr_i,
    input  logic [2:0]      imm_src_i,
    output logic [XLEN-1:0] imm_ext_o,
    output logic            imm_err_o
);

    typedef logic [XLEN-1:0] word_t;

    logic [5:0] shamt;
    logic       unused_opcode;

    // RV64 shifts carry a 6-bit amount; RV32 only 5.
    assign shamt = (XLEN == XLEN_64) ? instr_i[25:20]
                                     : {1'b0, instr_i[24:20]};

    assign unused_opcode = ^instr_i[6:0];

    // Size casts of signed operands sign-extend, unsigned ones zero-extend.
    always_comb begin
        imm_ext_o = '0;
        imm_err_o = 1'b0;
        unique case (imm_src_e'(imm_src_i))
            IMM_I: imm_ext_o = word_t'($signed(instr_i[31:20]));
            IMM_S: imm_ext_o = word_t'($signed({instr_i[31:25],
                                                instr_i[11:7]}));
            IMM_B: imm_ext_o = word_t'($signed({instr_i[31],
                                                instr_i[7],
                                                instr_i[30:25],
                                                instr_i[11:8],
                                                1'b0}));
            IMM_U: imm_ext_o = word_t'($signed({instr_i[31:12],
                                                12'b0}));
            IMM_J: imm_ext_o = word_t'($signed({instr_i[31],
                                                instr_i[19:12],
                                                instr_i[20],
                                                instr_i[30:21],
                                                1'b0}));
            IMM_Z:   imm_ext_o = word_t'(instr_i[19:15]);
            IMM_SH:  imm_ext_o = word_t'(shamt);
            IMM_ILL: imm_err_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_ext_stage.sv
// imm_ext_stage: one-cycle registered immediate + PC-target stage with
// valid/ready handshake. IMM_EXT_SKID_EN adds a second skid entry so that
// in_ready no longer depends combinationally on out_ready.
// Ports: clk, reset (sync, high); in_valid/in_ready, instr, imm_src, pc;
//        out_valid/out_ready, imm_ext, target, imm_err.
module imm_ext_stage
    import imm_ext_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [2:0]      imm_src,
    input  logic [XLEN-1:0] pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] imm_ext,
    output logic [XLEN-1:0] target,
    output logic            imm_err
);

    if (!xlen_ok(XLEN)) begin : g_bad_xlen
        $error("imm_ext_stage: XLEN must be 32 or 64");
    end

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] tgt;
        logic            err;
    } res_t;

    logic [XLEN-1:0] dec_imm;
    logic            dec_err;
    res_t            new_res;
    res_t            out_q, out_d;
    imm_state_e      state_q, state_d;
    logic            accept;
    logic            consume;

    imm_decode #(
        .XLEN(XLEN)
    ) u_dec (
        .instr_i  (instr),
        .imm_src_i(imm_src),
        .imm_ext_o(dec_imm),
        .imm_err_o(dec_err)
    );

    // Illegal selects decode to zero, so the target falls back to pc.
    assign new_res.imm = dec_imm;
    assign new_res.tgt = pc + dec_imm;
    assign new_res.err = dec_err;

    assign out_valid = (state_q != ST_EMPTY);
    assign consume   = out_valid && out_ready;
    assign accept    = in_valid && in_ready;

`ifdef IMM_EXT_SKID_EN
    res_t skid_q, skid_d;

    // Only registered state and reset feed in_ready.
    assign in_ready = !reset && (state_q != ST_TWO);
`else
    assign in_ready = !reset && (!out_valid || out_ready);
`endif

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
`ifdef IMM_EXT_SKID_EN
        skid_d  = skid_q;
`endif
        unique case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    out_d   = new_res;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && consume) begin
                    out_d = new_res;
`ifdef IMM_EXT_SKID_EN
                end else if (accept) begin
                    skid_d  = new_res;
                    state_d = ST_TWO;
`endif
                end else if (consume) begin
                    state_d = ST_EMPTY;
                end
            end
`ifdef IMM_EXT_SKID_EN
            ST_TWO: begin
                if (consume) begin
                    out_d   = skid_q;
                    state_d = ST_ONE;
                end
            end
`endif
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            out_q   <= '0;
`ifdef IMM_EXT_SKID_EN
            skid_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
`ifdef IMM_EXT_SKID_EN
            skid_q  <= skid_d;
`endif
        end
    end

    assign imm_ext = out_q.imm;
    assign target  = out_q.tgt;
    assign imm_err = out_q.err;

endmodule

// File: doc/imm_ext_stage.md
# imm_ext_stage

Registered immediate-generation stage for the RISC-V decode path, successor to the combinational immediate extender. It takes an instruction word, immediate-format select and PC, and produces the sign- or zero-extended immediate at XLEN width (32 or 64) plus the PC-relative target `pc + imm`. It adds CSR-immediate and shift-amount formats, flags illegal selects, and sits between fetch and execute behind a valid/ready handshake with one cycle of latency.

## Interface
Parameters:
- `XLEN`, 32: datapath width; only 32 or 64 are legal (elaboration error otherwise).

Ports:
- `clk`  in  1  — single clock; all state on rising edge.
- `reset`  in  1  — synchronous, active-high.
- `in_valid`  in  1  — upstream presents a request.
- `in_ready`  out  1  — stage accepts a request this cycle.
- `instr`  in  32  — instruction word; bits [6:0] ignored.
- `imm_src`  in  3  — format select (encodings under Operation).
- `pc`  in  XLEN  — PC of `instr`.
- `out_valid`  out  1  — result held on outputs.
- `out_ready`  in  1  — downstream consumes the result.
- `imm_ext`  out  XLEN  — extended immediate.
- `target`  out  XLEN  — `pc + imm_ext` mod 2^XLEN.
- `imm_err`  out  1  — illegal `imm_src` for this result.

## Operation
- Accept when `in_valid && in_ready`. Accepted requests are decoded combinationally and the result is registered.
- Formats; every signed format sign-extends from `instr[31]` to XLEN:
  - 000 I: `instr[31:20]`.
  - 001 S: `{instr[31:25], instr[11:7]}`.
  - 010 B: `{instr[31], instr[7], instr[30:25], instr[11:8], 0}`.
  - 011 U: `{instr[31:12], 12'b0}`, sign-extended above bit 31 when XLEN=64.
  - 100 J: `{instr[31], instr[19:12], instr[20], instr[30:21], 0}`.
  - 101 Z: `instr[19:15]`, zero-extended.
  - 110 SH: `instr[25:20]` when XLEN=64, else `instr[24:20]`; zero-extended.
  - 111: illegal. `imm_ext` = 0, `target` = `pc`, `imm_err` = 1.
- `target` is computed for every format; the adder is XLEN wide and carry-out is discarded (wrap-around).
- Results leave in acceptance order. No request is dropped or duplicated.

## Timing
- Latency: a request accepted in cycle N appears with `out_valid`=1 in cycle N+1.
- Throughput: one result per cycle while `out_ready`=1.
- Outputs are stable while `out_valid && !out_ready`.
- Reset values: `out_valid`=0, `imm_ext`=0, `target`=0, `imm_err`=0.
- `in_ready`=0 during any cycle with `reset`=1, and 1 in the first cycle after reset.
- Reset mid-operation discards all held results in the next cycle; nothing already held is presented afterwards.
- Simultaneous accept and consume in one cycle: the new result replaces the old one, with no bubble.
- State machine (`IMM_EXT_SKID_EN` defined): EMPTY, ONE, TWO.
  - EMPTY→ONE on accept.
  - ONE→TWO on accept with `!out_ready`.
  - ONE→EMPTY on consume without accept.
  - TWO→ONE on consume.
  - TWO never accepts.
- State machine (`IMM_EXT_SKID_EN` undefined): EMPTY and ONE only, transitions as above, no TWO.

## Configuration
- `IMM_EXT_SKID_EN` defined:
  - Adds a second skid entry.
  - `in_ready` is a pure register output (`!(state==TWO)`), so there is no combinational path from `out_ready` to `in_ready`.
  - The skid entry drains into the output register on consume.
- `IMM_EXT_SKID_EN` undefined:
  - Single output register.
  - `in_ready = !out_valid || out_ready` (combinational).
- The decoded values are identical in both builds; only the backpressure timing differs.

## Structure
- Package `imm_ext_pkg`:
  - `imm_src_e` enum (IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_Z, IMM_SH, IMM_ILL).
  - State enum `imm_state_e`.
  - Localparam for supported XLEN values.
- Sub-module `imm_decode`: purely combinational, parametrised on XLEN, maps `instr`/`imm_src` to `imm_ext`/`imm_err`.
- The top level holds the adder, handshake, state register and data registers.

## Test plan
- XLEN=32: `instr`=0xFFF00093, I → `imm_ext`=0xFFFFFFFF one cycle after accept; `imm_err`=0.
- XLEN=32: `instr`=0xFE000EE3, B, `pc`=0x00001000 → `imm_ext`=0xFFFFFFFC, `target`=0x00000FFC.
- XLEN=64: `instr`=0x80000037, U → `imm_ext`=0xFFFFFFFF80000000. Then Z with `instr[19:15]`=0x1F → 0x1F. Then SH with `instr[25:20]`=0x3F → 0x3F.
- `imm_src`=111, `pc`=0x40 → `imm_ext`=0, `target`=0x40, `imm_err`=1.
- Push 3 back-to-back requests with `out_ready`=0 for 3 cycles:
  - SKID_EN: `in_ready` falls after the 2nd accept.
  - Non-SKID: `in_ready` falls after the 1st accept.
  - Release: results emerge in order, none lost.
- Assert `reset` while in ONE/TWO → next cycle `out_valid`=0 and all outputs are 0; no stale result appears afterwards.
